hd44780_bus_ctrl: RTL and testbench
===================================

# hd44780_bus_ctrl

Write sequencer for the HD44780 parallel bus. It accepts one command or data byte at a time over a valid/ready handshake. It drives RS, RW, E and DB with programmable setup, enable-pulse and hold times, then enforces the controller's post-write execution delay before accepting the next byte. It sits between the init/character-streaming logic and the LCD pins, and supports both 8-bit and 4-bit (two-nibble) bus modes.

## Interface
- SETUP_CYC, default 4: cycles RS/DB are stable with E=0 before E rises (≥1).
- PULSE_CYC, default 12: cycles E is held high (≥1).
- HOLD_CYC, default 4: cycles RS/DB stay stable after E falls (≥1).
- SHORT_WAIT, default 2000: post-write wait cycles for ordinary commands and data (≥1).
- LONG_WAIT, default 80000: post-write wait cycles for clear/home commands (≥1).
- MODE4, default 0: 0 selects the 8-bit bus; 1 selects the 4-bit bus on DB[7:4].
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_rs  input  1  0 = command, 1 = data.
- in_data  input  8  byte to write.
- busy  output  1  high whenever not in IDLE (equal to ~in_ready).
- lcd_rs  output  1  register select to the LCD.
- lcd_rw  output  1  read/write; constant 0 (write only).
- lcd_e  output  1  enable strobe.
- lcd_db  output  8  data bus.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, WAIT. A single down-counter serves all timed states.
- Counter width: wide enough for max(LONG_WAIT, SHORT_WAIT, SETUP_CYC, PULSE_CYC, HOLD_CYC); no truncation allowed.
- **Accept:** in the cycle where in_valid & in_ready, latch in_rs and in_data, load lcd_rs and lcd_db, and go to SETUP.
- **Wait selection:** latch long_wait = (in_rs==0) & (in_data[7:2]==0) & (in_data[1:0]!=0), i.e. commands 0x01–0x03. Otherwise use SHORT_WAIT.
- **8-bit mode:** lcd_db = in_data. The path is SETUP(SETUP_CYC) -> PULSE(PULSE_CYC, lcd_e=1) -> HOLD(HOLD_CYC) -> WAIT -> IDLE.
- **4-bit mode:**
  - First pass: lcd_db = {in_data[7:4], 4'b0} through SETUP/PULSE/HOLD.
  - After HOLD: load lcd_db = {in_data[3:0], 4'b0} and return to SETUP for the second pass.
  - After the second HOLD: go to WAIT.
  - A nibble flag tracks which pass is active.
- lcd_e is registered and is 1 only in PULSE. lcd_rs and lcd_db change only on accept or on the nibble switch, never while lcd_e=1.
- in_valid, in_rs and in_data are ignored outside IDLE.
- lcd_rw is tied to 0.

## Timing
- **Reset values:** state=IDLE, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=8'h00, nibble flag=0, counter=0, in_ready=1, busy=0.
- Reset asserted mid-transfer aborts immediately and asynchronously: lcd_e drops to 0 that instant, and nothing resumes after release.
- With accept at cycle T:
  - lcd_e rises at cycle T+1+SETUP_CYC.
  - lcd_e is high for exactly PULSE_CYC cycles.
- **8-bit:** in_ready is low for exactly SETUP_CYC+PULSE_CYC+HOLD_CYC+W cycles (W = selected wait), and high again at cycle T+1+that count.
- **4-bit:** in_ready is low for 2*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+W cycles.
- **Back-to-back:** if in_valid is held, the next byte is accepted on the first cycle in_ready is high. There is no extra idle cycle.
- in_ready/busy are decoded from state: combinational and glitch-free relative to clk.

## Test plan
Bench parameters: SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, SHORT_WAIT=5, LONG_WAIT=20.

- **8-bit data write**, MODE4=0, rs=1, data 0x41:
  - lcd_rs=1 and lcd_db=0x41 the cycle after accept.
  - lcd_e high for cycles T+3..T+5.
  - in_ready low for 12 cycles.
- **Clear command**, rs=0, data 0x01: in_ready low for 27 cycles. Repeat with 0x02 and 0x03 (27 cycles each) and with 0x04 (12 cycles).
- **4-bit data write**, MODE4=1, rs=1, data 0xA5:
  - Two E pulses of 3 cycles each.
  - lcd_db=0xA0 during the first pulse and 0x50 during the second.
  - in_ready low for 19 cycles.
- **Back-to-back**, in_valid held with 0x30 then 0x38:
  - Second accept occurs on the first in_ready=1 cycle.
  - lcd_db never changes while lcd_e=1.
  - in_data changes during busy are ignored.
- **Reset mid-operation:** assert rst during PULSE.
  - lcd_e=0 and lcd_db=0x00 immediately; in_ready=1.
  - After release, a new 0x41 write completes with nominal timing.

Source files
------------

// File: rtl/hd44780_bus_ctrl_if.sv
// Upstream handshake and LCD pin bundle for the HD44780 write sequencer.
// The slave modport is the sequencer. The master modport is the byte source,
// which also observes the LCD pins.
interface hd44780_bus_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       busy;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, busy, lcd_rs, lcd_rw, lcd_e, lcd_db
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, busy, lcd_rs, lcd_rw, lcd_e, lcd_db
  );
endinterface

// File: rtl/hd44780_bus_ctrl.sv
// HD44780 write sequencer.
// Takes one command/data byte per handshake and strobes it onto the LCD bus
// with programmable setup, enable-pulse and hold times. It then waits out
// the controller execution time before accepting the next byte.
// In 4-bit mode the byte goes out as two nibbles on DB[7:4], high nibble first.
module hd44780_bus_ctrl #(
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 12,
  parameter int HOLD_CYC   = 4,
  parameter int SHORT_WAIT = 2000,
  parameter int LONG_WAIT  = 80000,
  parameter int MODE4      = 0
) (
  input  logic               clk,
  input  logic               rst,
  hd44780_bus_ctrl_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  localparam bit FOUR_BIT = (MODE4 != 0);

  // One shared down-counter. It must be wide enough for the largest interval.
  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B   = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int MAX_C   = (MAX_B > SHORT_WAIT) ? MAX_B : SHORT_WAIT;
  localparam int MAX_CYC = (MAX_C > LONG_WAIT) ? MAX_C : LONG_WAIT;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Each timed state is loaded with (length - 1) and exits when the count reaches zero.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_WAIT - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nib_q, nib_d;      // 0: first (or only) pass, 1: low-nibble pass
  logic          long_q, long_d;    // clear/home commands need the long wait
  logic [3:0]    lo_nib_q, lo_nib_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [7:0]    lcd_db_q, lcd_db_d;
  logic          lcd_e_q, lcd_e_d;

  // Next-state, counter and bus-value decode for the sequencer.
  // NOTE: every signal gets a default at the top so no path leaves a value unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nib_d    = nib_q;
    long_d   = long_q;
    lo_nib_d = lo_nib_q;
    lcd_rs_d = lcd_rs_q;
    lcd_db_d = lcd_db_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d  = ST_SETUP;
          cnt_d    = SETUP_LD;
          nib_d    = 1'b0;
          long_d   = !bus.in_rs && (bus.in_data[7:2] == 6'd0) && (bus.in_data[1:0] != 2'd0);
          lo_nib_d = bus.in_data[3:0];
          lcd_rs_d = bus.in_rs;
          lcd_db_d = FOUR_BIT ? {bus.in_data[7:4], 4'h0} : bus.in_data;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          if (FOUR_BIT && !nib_q) begin
            // E is already low here, so switching the nibble cannot glitch a strobe.
            state_d  = ST_SETUP;
            cnt_d    = SETUP_LD;
            nib_d    = 1'b1;
            lcd_db_d = {lo_nib_q, 4'h0};
          end else begin
            state_d = ST_WAIT;
            cnt_d   = long_q ? LONG_LD : SHORT_LD;
            nib_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // E is registered from the next state so it is high exactly while in PULSE.
  assign lcd_e_d = (state_d == ST_PULSE);

  // Sequencer registers; the asynchronous reset drops E immediately and aborts any transfer.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      nib_q    <= 1'b0;
      long_q   <= 1'b0;
      lo_nib_q <= 4'h0;
      lcd_rs_q <= 1'b0;
      lcd_db_q <= 8'h00;
      lcd_e_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nib_q    <= nib_d;
      long_q   <= long_d;
      lo_nib_q <= lo_nib_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_db_q <= lcd_db_d;
      lcd_e_q  <= lcd_e_d;
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.lcd_rs   = lcd_rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = lcd_e_q;
  assign bus.lcd_db   = lcd_db_q;

endmodule

// File: tb/tb_hd44780_bus_ctrl.sv
// Scoreboard bench for hd44780_bus_ctrl.
// Two instances are used: one in 8-bit mode and one in 4-bit mode.
// Drivers push the expected transfer shape into a queue when they issue a byte.
// A per-DUT monitor follows every accepted transfer on the pins and compares it when in_ready returns.
module tb_hd44780_bus_ctrl;

  localparam int S  = 2;
  localparam int P  = 3;
  localparam int H  = 2;
  localparam int SW = 5;
  localparam int LW = 20;

  typedef struct {
    bit       rs;
    int       busy_len;
    int       npulses;
    bit [7:0] db0;
    bit [7:0] db1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       v_valid [2];
  logic       v_rs    [2];
  logic [7:0] v_data  [2];

  hd44780_bus_ctrl_if bus8 ();
  hd44780_bus_ctrl_if bus4 ();

  assign bus8.in_valid = v_valid[0];
  assign bus8.in_rs    = v_rs[0];
  assign bus8.in_data  = v_data[0];
  assign bus4.in_valid = v_valid[1];
  assign bus4.in_rs    = v_rs[1];
  assign bus4.in_data  = v_data[1];

  hd44780_bus_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
                     .SHORT_WAIT(SW), .LONG_WAIT(LW), .MODE4(0))
    u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  hd44780_bus_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
                     .SHORT_WAIT(SW), .LONG_WAIT(LW), .MODE4(1))
    u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int total = 0;
  int bad   = 0;

  exp_t q8[$];
  exp_t q4[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: derive the transfer shape straight from the byte and the bus mode.
  function automatic exp_t model(input bit m4, input bit rs, input bit [7:0] d);
    exp_t e;
    int w;
    w = (!rs && d >= 8'h01 && d <= 8'h03) ? LW : SW;
    e.rs       = rs;
    e.npulses  = m4 ? 2 : 1;
    e.busy_len = e.npulses * (S + P + H) + w;
    e.db0      = m4 ? {d[7:4], 4'h0} : d;
    e.db1      = {d[3:0], 4'h0};
    return e;
  endfunction

  function automatic logic rdy(input int m);
    return (m == 0) ? bus8.in_ready : bus4.in_ready;
  endfunction

  // ---------------- monitor ----------------
  bit       act    [2];
  exp_t     cur    [2];
  int       cyc    [2];
  int       busy_n [2];
  int       np     [2];
  int       plen   [2][2];
  int       rise   [2][2];
  bit [7:0] pdb    [2][2];
  int       db_bad [2];
  int       rs_bad [2];
  int       hs_bad [2];
  logic     prev_e [2];

  task automatic mon_step(input int m, input logic ready, input logic valid, input logic busy,
                          input logic e, input logic rs, input logic rw, input logic [7:0] db);
    if (!rst) begin
      act[m]    = 1'b0;
      prev_e[m] = 1'b0;
      return;
    end
    if (busy == ready || rw !== 1'b0) hs_bad[m]++;
    if (act[m]) begin
      cyc[m]++;
      if (ready) begin
        check($sformatf("busy_len[%0d]", m), busy_n[m], cur[m].busy_len);
        check($sformatf("pulses[%0d]", m), np[m], cur[m].npulses);
        check($sformatf("pulse0_len[%0d]", m), plen[m][0], P);
        check($sformatf("rise0[%0d]", m), rise[m][0], 1 + S);
        check($sformatf("pulse0_db[%0d]", m), pdb[m][0], cur[m].db0);
        if (cur[m].npulses == 2) begin
          check($sformatf("pulse1_len[%0d]", m), plen[m][1], P);
          check($sformatf("rise1[%0d]", m), rise[m][1], 1 + S + P + H + S);
          check($sformatf("pulse1_db[%0d]", m), pdb[m][1], cur[m].db1);
        end
        check($sformatf("db_stable_in_e[%0d]", m), db_bad[m], 0);
        check($sformatf("rs_stable[%0d]", m), rs_bad[m], 0);
        check($sformatf("rw_busy_decode[%0d]", m), hs_bad[m], 0);
        act[m] = 1'b0;
      end else begin
        busy_n[m]++;
        if (cyc[m] == 1) begin
          check($sformatf("accept_taken[%0d]", m), busy, 1);
          check($sformatf("first_db[%0d]", m), db, cur[m].db0);
          check($sformatf("first_rs[%0d]", m), rs, cur[m].rs);
        end
        if (rs !== cur[m].rs) rs_bad[m]++;
        if (e) begin
          if (!prev_e[m]) begin
            np[m]++;
            if (np[m] <= 2) begin
              rise[m][np[m]-1] = cyc[m];
              pdb[m][np[m]-1]  = db;
            end
          end
          if (np[m] >= 1 && np[m] <= 2) begin
            plen[m][np[m]-1]++;
            if (db !== pdb[m][np[m]-1]) db_bad[m]++;
          end
        end
      end
    end
    prev_e[m] = e;
    if (ready && valid) begin
      if ((m == 0 && q8.size() == 0) || (m == 1 && q4.size() == 0)) begin
        check($sformatf("unexpected_accept[%0d]", m), 1, 0);
        cur[m] = model(m == 1, 1'b0, 8'h00);
      end else begin
        cur[m] = (m == 0) ? q8.pop_front() : q4.pop_front();
      end
      act[m]    = 1'b1;
      cyc[m]    = 0;
      busy_n[m] = 0;
      np[m]     = 0;
      db_bad[m] = 0;
      rs_bad[m] = 0;
      hs_bad[m] = 0;
      for (int i = 0; i < 2; i++) begin
        plen[m][i] = 0;
        rise[m][i] = 0;
        pdb[m][i]  = 8'h00;
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, bus8.in_ready, bus8.in_valid, bus8.busy, bus8.lcd_e, bus8.lcd_rs, bus8.lcd_rw, bus8.lcd_db);
    mon_step(1, bus4.in_ready, bus4.in_valid, bus4.busy, bus4.lcd_e, bus4.lcd_rs, bus4.lcd_rw, bus4.lcd_db);
  end

  // ---------------- drivers ----------------
  // Present one byte; while the DUT is busy scribble the inputs, which it must ignore.
  task automatic drive(input int m, input bit rs, input bit [7:0] d, input bit hold);
    exp_t e;
    bit   ok;
    e = model(m == 1, rs, d);
    if (m == 0) q8.push_back(e); else q4.push_back(e);
    v_valid[m] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rdy(m)) begin
        v_rs[m]   = rs;
        v_data[m] = d;
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      v_rs[m]   = 1'($urandom);
      v_data[m] = 8'($urandom);
      @(posedge clk); #1;
    end
    if (!ok) check($sformatf("accept_timeout[%0d]", m), 0, 1);
    if (!hold) v_valid[m] = 1'b0;
  endtask

  task automatic wait_idle(input int m);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rdy(m)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check($sformatf("idle_timeout[%0d]", m), 0, 1);
    @(negedge clk);
  endtask

  task automatic random_stream(input int m, input int n);
    bit [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      drive(m, 1'($urandom_range(0, 1)), d, (i != n - 1) && ($urandom_range(0, 1) == 1));
    end
    wait_idle(m);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      v_valid[m] = 1'b0;
      v_rs[m]    = 1'b0;
      v_data[m]  = 8'h00;
      act[m]     = 1'b0;
      prev_e[m]  = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready8", bus8.in_ready, 1);
    check("rst_busy8",  bus8.busy, 0);
    check("rst_e8",     bus8.lcd_e, 0);
    check("rst_rs8",    bus8.lcd_rs, 0);
    check("rst_rw8",    bus8.lcd_rw, 0);
    check("rst_db8",    bus8.lcd_db, 8'h00);
    check("rst_ready4", bus4.in_ready, 1);
    check("rst_e4",     bus4.lcd_e, 0);
    check("rst_db4",    bus4.lcd_db, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;

    // 8-bit data write, then the long/short wait boundary commands
    drive(0, 1'b1, 8'h41, 1'b0); wait_idle(0);
    drive(0, 1'b0, 8'h01, 1'b0); wait_idle(0);
    drive(0, 1'b0, 8'h02, 1'b0); wait_idle(0);
    drive(0, 1'b0, 8'h03, 1'b0); wait_idle(0);
    drive(0, 1'b0, 8'h04, 1'b0); wait_idle(0);
    drive(0, 1'b0, 8'h00, 1'b0); wait_idle(0);
    drive(0, 1'b1, 8'h01, 1'b0); wait_idle(0);

    // 4-bit data write and a 4-bit clear
    @(posedge clk); #1;
    drive(1, 1'b1, 8'hA5, 1'b0); wait_idle(1);
    drive(1, 1'b0, 8'h01, 1'b0); wait_idle(1);

    // Back-to-back with in_valid held
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h30, 1'b1);
    drive(0, 1'b0, 8'h38, 1'b0);
    wait_idle(0);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h30, 1'b1);
    drive(1, 1'b0, 8'h38, 1'b0);
    wait_idle(1);

    // Randomized traffic on both instances concurrently
    @(posedge clk); #1;
    fork
      random_stream(0, 25);
      random_stream(1, 25);
    join

    // Reset during PULSE, then a nominal write afterwards
    @(posedge clk); #1;
    drive(0, 1'b1, 8'h41, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("in_pulse_e", bus8.lcd_e, 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_e",     bus8.lcd_e, 0);
    check("abort_db",    bus8.lcd_db, 8'h00);
    check("abort_ready", bus8.in_ready, 1);
    check("abort_busy",  bus8.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_e", bus8.lcd_e, 0);
    check("post_rst_ready", bus8.in_ready, 1);
    drive(0, 1'b1, 8'h41, 1'b0);
    wait_idle(0);

    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);
    check("mon8_idle", int'(act[0]), 0);
    check("mon4_idle", int'(act[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
